// File: rtl/ibex_pkg.sv
// Shared core types used by the PMP channel arbiter.
package ibex_pkg;

  typedef enum logic [1:0] {
    PRIV_LVL_M = 2'b11,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_U = 2'b00
  } priv_lvl_e;

  typedef enum logic [1:0] {
    PMP_ACC_EXEC  = 2'b00,
    PMP_ACC_WRITE = 2'b01,
    PMP_ACC_READ  = 2'b10
  } pmp_req_e;

  typedef enum logic [1:0] {
    PMP_ARB_IDLE  = 2'b00,
    PMP_ARB_CHECK = 2'b01,
    PMP_ARB_RESP  = 2'b10
  } pmp_arb_state_e;

endpackage

// File: rtl/ibex_pmp_chan_arb_pkg.sv
// Arbiter-local constants and the round-robin index helper.
package ibex_pmp_chan_arb_pkg;

  localparam int unsigned PmpAddrW = 34;

  // (base + off) mod n, valid for base < n and off < n.
  function automatic int unsigned rr_add(input int unsigned base,
                                         input int unsigned off,
                                         input int unsigned n);
    int unsigned sum;
    sum = base + off;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

// File: rtl/ibex_pmp_chan_arb_if.sv
// Requester, response and PMP-channel signals of the shared PMP arbiter.
interface ibex_pmp_chan_arb_if #(
  parameter int unsigned NumReq = 3
);
  import ibex_pkg::*;
  import ibex_pmp_chan_arb_pkg::*;

  logic [NumReq-1:0]               req_valid_i;
  logic [NumReq-1:0]               req_ready_o;
  logic [NumReq-1:0][PmpAddrW-1:0] req_addr_i;
  pmp_req_e  [NumReq-1:0]          req_type_i;
  priv_lvl_e [NumReq-1:0]          req_priv_i;
  logic [NumReq-1:0]               rsp_valid_o;
  logic [NumReq-1:0]               rsp_ready_i;
  logic                            rsp_err_o;
  logic                            csr_pmp_change_i;
  logic [PmpAddrW-1:0]             pmp_req_addr_o;
  pmp_req_e                        pmp_req_type_o;
  priv_lvl_e                       pmp_priv_mode_o;
  logic                            pmp_req_err_i;

  // Requesters, CSR retire logic and the PMP checker drive this side.
  modport master (
    output req_valid_i, req_addr_i, req_type_i, req_priv_i, rsp_ready_i,
    output csr_pmp_change_i, pmp_req_err_i,
    input  req_ready_o, rsp_valid_o, rsp_err_o,
    input  pmp_req_addr_o, pmp_req_type_o, pmp_priv_mode_o
  );

  // The arbiter itself.
  modport slave (
    input  req_valid_i, req_addr_i, req_type_i, req_priv_i, rsp_ready_i,
    input  csr_pmp_change_i, pmp_req_err_i,
    output req_ready_o, rsp_valid_o, rsp_err_o,
    output pmp_req_addr_o, pmp_req_type_o, pmp_priv_mode_o
  );

endinterface

// File: rtl/ibex_pmp_rr_picker.sv
// Combinational round-robin priority encoder: first valid bit at or after rr_q.
module ibex_pmp_rr_picker
  import ibex_pmp_chan_arb_pkg::*;
#(
  parameter int unsigned NumReq = 3,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid,
  input  logic [IdxW-1:0]   rr_q,
  output logic [IdxW-1:0]   gnt_idx,
  output logic              gnt_valid
);

  logic [IdxW-1:0] cand;

  // Walk the requesters from rr_q with wrap-around, keep the first hit.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdxW'(rr_add(32'(rr_q), i, NumReq));
      if (!gnt_valid && valid[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ibex_pmp_chan_arb.sv
// Shares one PMP checking channel among NumReq requesters (round-robin),
// re-checking whenever PMP CSRs change while a check is in flight.
module ibex_pmp_chan_arb
  import ibex_pkg::*;
  import ibex_pmp_chan_arb_pkg::*;
#(
  parameter int unsigned NumReq = 3,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input logic                clk_i,
  input logic                rst_i,
  ibex_pmp_chan_arb_if.slave bus
);

  pmp_arb_state_e      state_q;
  logic [IdxW-1:0]     rr_q;
  logic [IdxW-1:0]     owner_q;
  logic                err_q;
  logic [NumReq-1:0]   rsp_valid_q;
  logic [PmpAddrW-1:0] pmp_addr_q;
  pmp_req_e            pmp_type_q;
  priv_lvl_e           pmp_priv_q;

  logic [IdxW-1:0]     gnt_idx;
  logic                gnt_valid;
  logic [IdxW-1:0]     rr_next;
  logic [NumReq-1:0]   owner_onehot;
  logic [NumReq-1:0]   req_ready;

  ibex_pmp_rr_picker #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_picker (
    .valid     (bus.req_valid_i),
    .rr_q      (rr_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign rr_next      = IdxW'(rr_add(32'(gnt_idx), 1, NumReq));
  assign owner_onehot = NumReq'(1) << owner_q;

  // Grant pulse is the only combinational output, and only while idle.
  always_comb begin
    req_ready = '0;
    if (state_q == PMP_ARB_IDLE && gnt_valid) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Arbitration FSM with registered channel and response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= PMP_ARB_IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      pmp_addr_q  <= '0;
      pmp_type_q  <= PMP_ACC_READ;
      pmp_priv_q  <= PRIV_LVL_M;
    end else begin
      unique case (state_q)
        PMP_ARB_IDLE: begin
          if (gnt_valid) begin
            owner_q    <= gnt_idx;
            pmp_addr_q <= bus.req_addr_i[gnt_idx];
            pmp_type_q <= bus.req_type_i[gnt_idx];
            pmp_priv_q <= bus.req_priv_i[gnt_idx];
            rr_q       <= rr_next;
            state_q    <= PMP_ARB_CHECK;
          end
        end
        PMP_ARB_CHECK: begin
          // A retiring PMP CSR write invalidates this cycle's result.
          if (!bus.csr_pmp_change_i) begin
            err_q       <= bus.pmp_req_err_i;
            rsp_valid_q <= owner_onehot;
            state_q     <= PMP_ARB_RESP;
          end
        end
        PMP_ARB_RESP: begin
          if (bus.rsp_ready_i[owner_q]) begin
            rsp_valid_q <= '0;
            state_q     <= PMP_ARB_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= '0;
          state_q     <= PMP_ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o     = req_ready;
  assign bus.rsp_valid_o     = rsp_valid_q;
  assign bus.rsp_err_o       = err_q;
  assign bus.pmp_req_addr_o  = pmp_addr_q;
  assign bus.pmp_req_type_o  = pmp_type_q;
  assign bus.pmp_priv_mode_o = pmp_priv_q;

endmodule

// File: doc/ibex_pmp_chan_arb.md
# ibex_pmp_chan_arb

Time-multiplexes one PMP checking channel among `NumReq` requesters, such as a debug-module system-bus master, a DMA-style prefetcher and a trace unit. Requests are arbitrated round-robin and registered onto one channel of the PMP checker. The combinational fault result is captured, then returned to the granted requester with a valid/ready handshake. A CSR-change indication forces a re-check, so no response is ever computed against stale PMP configuration.

## Interface
Parameters:
- `NumReq`, default 3: number of requesters, minimum 2.
- `IdxW`, default `$clog2(NumReq)`: width of the grant index. Derived; do not override.

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, synchronous, active-high
- `req_valid_i`  in  [NumReq]  request pending per requester
- `req_ready_o`  out  [NumReq]  grant pulse; the request is accepted when valid && ready
- `req_addr_i`  in  [NumReq][34]  physical address to check
- `req_type_i`  in  [NumReq] `pmp_req_e`  access type
- `req_priv_i`  in  [NumReq] `priv_lvl_e`  privilege of the access
- `rsp_valid_o`  out  [NumReq]  response valid, one-hot or zero
- `rsp_ready_i`  in  [NumReq]  response accepted
- `rsp_err_o`  out  1  access fault; meaningful while any `rsp_valid_o` bit is set
- `csr_pmp_change_i`  in  1  a pmpcfg, pmpaddr or mseccfg write is retiring this cycle
- `pmp_req_addr_o`  out  34  registered address to the PMP channel
- `pmp_req_type_o`  out  `pmp_req_e`  registered access type to the PMP channel
- `pmp_priv_mode_o`  out  `priv_lvl_e`  registered privilege to the PMP channel
- `pmp_req_err_i`  in  1  PMP fault result, combinational from the `pmp_*_o` outputs

## Operation
The block is a three-state FSM: IDLE, CHECK, RESP.

IDLE:
- Search `req_valid_i` starting at `rr_q` and wrapping modulo `NumReq`; the first set bit wins (index `g`).
- Assert `req_ready_o[g]` combinationally, this cycle only.
- Load `g` into `owner_q`, and load that requester's addr, type and priv into the `pmp_*_o` registers.
- Update `rr_q <= (g+1) mod NumReq`, then go to CHECK.
- If no request is valid, stay in IDLE with all `req_ready_o` low.

CHECK:
- The `pmp_*_o` outputs are stable; sample `pmp_req_err_i` into `err_q`.
- If `csr_pmp_change_i` is 1, discard the sample and stay in CHECK (re-check next cycle). Otherwise go to RESP.

RESP:
- `rsp_valid_o[owner_q]=1` and `rsp_err_o=err_q`, held stable until `rsp_ready_i[owner_q]`.
- On the handshake, go to IDLE.
- `csr_pmp_change_i` in RESP is ignored: the check has already completed and the result is committed.

Other rules:
- `req_ready_o` is zero outside IDLE.
- Requesters must hold their request until it is granted; the block never drops an accepted request.
- `rsp_ready_i` bits of non-owners are ignored.
- The `pmp_*_o` registers hold their last value outside CHECK.

Reset values (all outputs and registers):
- State IDLE.
- `rr_q=0`, `owner_q=0`, `err_q=0`.
- `req_ready_o=0`, `rsp_valid_o=0`, `rsp_err_o=0`.
- `pmp_req_addr_o=0`, `pmp_req_type_o=PMP_ACC_READ`, `pmp_priv_mode_o=PRIV_LVL_M`.

## Timing
- Accept in cycle N, check in cycle N+1, `rsp_valid_o` asserted in cycle N+2 at minimum.
- Each `csr_pmp_change_i` cycle during CHECK adds one cycle of latency.
- Maximum throughput is one request per 3 cycles; the next grant comes no earlier than the cycle after the response handshake.
- There is no combinational path from `pmp_req_err_i` to any output. The only combinational output path is `req_valid_i` to `req_ready_o`, in IDLE only.
- Reset asserted mid-operation discards the in-flight request with no response; the block returns to its reset values on the next edge.

## Structure
- `ibex_pkg` owns `pmp_req_e` and `priv_lvl_e`.
- `ibex_pkg` gains `pmp_arb_state_e` (IDLE/CHECK/RESP, 2 bits).
- One sub-module is natural: `ibex_pmp_rr_picker`, a combinational round-robin priority encoder with inputs `valid`, `rr_q` and outputs `gnt_idx`, `gnt_valid`. It is reusable by other shared-resource arbiters.
- The FSM and registers live in `ibex_pmp_chan_arb`.

## Test plan
1. Single request, requester 1, addr 34'h0_8000_0000, PMP_ACC_READ, PRIV_LVL_U, PMP returns err=1 → `req_ready_o[1]` pulses in cycle N, `pmp_req_addr_o=34'h0_8000_0000` from N+1, `rsp_valid_o[1]=1` with `rsp_err_o=1` in N+2.
2. All three requesters valid continuously from reset → grant order 0,1,2,0,1,2; `rr_q` wraps from 2 to 0.
3. `csr_pmp_change_i` high for 2 cycles during CHECK; PMP err changes from 0 to 1 mid-way → response is delayed 2 cycles and `rsp_err_o=1` (the post-change value).
4. Response backpressure: `rsp_ready_i` low for 5 cycles → `rsp_valid_o` and `rsp_err_o` stay stable; other requesters see `req_ready_o=0` throughout; `rsp_ready_i` on a non-owner is ignored.
5. Reset asserted in CHECK → the next cycle shows every output at its reset value, no response is issued, and the first post-reset grant goes to requester 0.
6. Only requester 2 valid while `rr_q=0` → requester 2 is granted, then `rr_q=0` again (wrap from index 2).
